// File: rtl/calc_pkg.sv
// Shared opcode/state types and display status codes for calc_core and the
// seven-segment driver side.
package calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } calc_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } calc_state_t;

   // Status codes understood by the display driver ("nr" and "cd").
   localparam logic signed [8:0] NR_CODE = 9'sh1F0;
   localparam logic signed [8:0] CD_CODE = 9'sh1EF;
   // Most negative displayable difference; keeps -16/-17 reserved for codes.
   localparam logic signed [8:0] SUB_MIN = 9'sh1F1;

   localparam int unsigned ITER_COUNT = 8;

endpackage

// File: rtl/calc_core_seq_muldiv.sv
// Iterative unit: shift-add multiply or restoring divide, one bit per clock.
// Loaded by a one-cycle go; fin flags the cycle whose outputs are final.
module seq_muldiv
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = ITER_COUNT
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               go,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  calc_op_t           mode,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   quotient,
   output logic               div0,
   output logic               fin
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [CW-1:0]      r_cnt;
   logic               r_active;
   logic               r_div;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH:0]     r_rem;

   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [WIDTH+1:0]   w_rem_sh;
   logic [WIDTH+1:0]   w_trial;
   logic               w_borrow;
   logic [WIDTH:0]     w_rem_nxt;
   logic [WIDTH-1:0]   w_quo_nxt;

   assign w_acc_nxt = r_b[0] ? (r_acc + r_mcand) : r_acc;

   // r_quo holds the dividend bits still to be consumed; quotient bits shift
   // in from the bottom as the dividend shifts out of the top.
   assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
   assign w_trial   = w_rem_sh - {2'b00, r_b};
   assign w_borrow  = w_trial[WIDTH+1];
   assign w_rem_nxt = w_borrow ? w_rem_sh[WIDTH:0] : w_trial[WIDTH:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};

   assign product  = w_acc_nxt;
   assign quotient = w_quo_nxt;
   assign div0     = r_div && (r_b == '0);
   assign fin      = r_active && (r_cnt == '0);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_div    <= 1'b0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_b      <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
      end else if (go) begin
         r_cnt    <= CW'(WIDTH - 1);
         r_active <= 1'b1;
         r_div    <= (mode == OP_DIV);
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, a};
         r_b      <= b;
         r_quo    <= a;
         r_rem    <= '0;
      end else if (r_active) begin
         if (r_cnt == '0) begin
            r_active <= 1'b0;
         end else begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (r_div) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
         end else begin
            r_acc   <= w_acc_nxt;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
         end
      end
   end

endmodule

// File: rtl/calc_core.sv
// Sequential add/sub/mul/div unit feeding the two-digit seven-segment driver.
// Define CALC_SAT_EN to saturate overflow/underflow instead of showing "nr".
module calc_core
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [1:0]       op,
   input  logic             start,
   output logic [WIDTH:0]   result,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH:0]        L_NR      = NR_CODE;
   localparam logic [WIDTH:0]        L_CD      = CD_CODE;
   localparam logic signed [WIDTH:0] L_SUB_LIM = SUB_MIN;
`ifdef CALC_SAT_EN
   localparam logic [WIDTH:0]        L_OVF     = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH:0]        L_UNF     = L_SUB_LIM;
`else
   localparam logic [WIDTH:0]        L_OVF     = L_NR;
   localparam logic [WIDTH:0]        L_UNF     = L_NR;
`endif

   calc_state_t        r_state, w_state_nxt;
   calc_op_t           r_op;
   logic [WIDTH-1:0]   r_a, r_b;
   logic [WIDTH:0]     r_result, w_result_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;

   logic               w_accept;
   logic               w_go;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot;
   logic               w_div0;
   logic               w_fin;
   logic [WIDTH:0]     w_alu_val;

   assign w_accept = start && (r_state != ST_CALC);
   assign w_go     = w_accept && op[1];

   seq_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk      (clk),
      .nrst     (nrst),
      .go       (w_go),
      .a        (a_in),
      .b        (b_in),
      .mode     (calc_op_t'(op)),
      .product  (w_prod),
      .quotient (w_quot),
      .div0     (w_div0),
      .fin      (w_fin)
   );

   assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff = {1'b0, r_a} - {1'b0, r_b};

   always_comb begin
      w_alu_val = '0;
      unique case (r_op)
         OP_ADD: w_alu_val = w_sum[WIDTH] ? L_OVF : w_sum;
         OP_SUB: w_alu_val = ($signed(w_diff) < L_SUB_LIM) ? L_UNF : w_diff;
         OP_MUL: w_alu_val = (|w_prod[2*WIDTH-1:WIDTH]) ? L_OVF
                                                         : {1'b0, w_prod[WIDTH-1:0]};
         OP_DIV: w_alu_val = w_div0 ? L_NR : {1'b0, w_quot};
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_result_nxt = r_result;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_nxt  = ST_CALC;
               w_result_nxt = L_CD;
               w_busy_nxt   = 1'b1;
            end
         end
         ST_CALC: begin
            if ((r_op == OP_ADD) || (r_op == OP_SUB) || w_fin) begin
               w_state_nxt  = ST_DONE;
               w_result_nxt = w_alu_val;
               w_busy_nxt   = 1'b0;
               w_done_nxt   = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state  <= ST_IDLE;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_result <= w_result_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_a  <= '0;
         r_b  <= '0;
         r_op <= OP_ADD;
      end else if (w_accept) begin
         r_a  <= a_in;
         r_b  <= b_in;
         r_op <= calc_op_t'(op);
      end
   end

   assign result = r_result;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core: stimulus queues expected results from an
// integer reference model; a negedge monitor checks them when done pulses.
module tb_calc_core;

   localparam logic [8:0] NR = 9'h1F0;
   localparam logic [8:0] CD = 9'h1EF;
`ifdef CALC_SAT_EN
   localparam logic [8:0] OVF = 9'h0FF;
   localparam logic [8:0] UNF = 9'h1F1;
`else
   localparam logic [8:0] OVF = NR;
   localparam logic [8:0] UNF = NR;
`endif

   typedef struct {
      logic [8:0] val;
      int         lat;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       nrst;
   logic [7:0] a_in, b_in;
   logic [1:0] op;
   logic       start;
   logic [8:0] result;
   logic       busy, done;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   busy_cnt = 0;
   int   cd_bad   = 0;

   calc_core #(.WIDTH(8)) dut (
      .clk    (clk),
      .nrst   (nrst),
      .a_in   (a_in),
      .b_in   (b_in),
      .op     (op),
      .start  (start),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] ref_calc(input int a, input int b, input int o);
      int r;
      if (o == 3 && b == 0) return NR;
      case (o)
         0:       r = a + b;
         1:       r = a - b;
         2:       r = a * b;
         default: r = a / b;
      endcase
      if (r > 255) return OVF;
      if (r < -15) return UNF;
      return 9'(r);
   endfunction

   // Expects to be entered just after a rising edge with the DUT able to accept.
   task automatic issue(input int a, input int b, input int o);
      exp_t e;
      a_in  = 8'(a);
      b_in  = 8'(b);
      op    = 2'(o);
      start = 1'b1;
      e.val = ref_calc(a, b, o);
      e.lat = (o >= 2) ? 8 : 1;
      e.tag = $sformatf("op%0d_%0d_%0d", o, a, b);
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         check("timeout_result", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic wait_done_rise(input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (done !== 1'b1) check("timeout_done", 0, 1);
   endtask

   always @(negedge clk) begin
      if (!nrst) begin
         busy_cnt = 0;
         cd_bad   = 0;
      end else begin
         if (busy) begin
            busy_cnt++;
            if (result !== CD) cd_bad = 1;
         end
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check({"result_", e.tag}, int'(result), int'(e.val));
               check({"busy_len_", e.tag}, busy_cnt, e.lat);
               check({"cd_hold_", e.tag}, cd_bad, 0);
            end
            busy_cnt = 0;
            cd_bad   = 0;
         end
      end
   end

   initial begin
      nrst  = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      op    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_result", int'(result), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      nrst = 1'b1;
      @(posedge clk); #1;

      issue(200, 55, 0);  wait_empty(30);
      issue(200, 56, 0);  wait_empty(30);
      issue(3, 10, 1);    wait_empty(30);
      issue(0, 16, 1);    wait_empty(30);
      issue(5, 5, 1);     wait_empty(30);
      issue(15, 17, 2);   wait_empty(30);
      issue(16, 16, 2);   wait_empty(30);
      issue(200, 7, 3);   wait_empty(30);
      issue(9, 0, 3);     wait_empty(30);

      // Starts and operand changes during CALC must be ignored.
      issue(200, 7, 3);
      for (int i = 0; i < 8; i++) begin
         a_in  = 8'($urandom_range(0, 255));
         b_in  = 8'($urandom_range(0, 255));
         op    = 2'($urandom_range(0, 3));
         start = 1'b1;
         @(posedge clk); #1;
      end
      start = 1'b0;
      wait_empty(30);

      // Start on the done cycle is accepted back-to-back.
      issue(10, 20, 0);
      wait_done_rise(30);
      issue(12, 11, 2);
      wait_done_rise(30);
      issue(1, 2, 1);
      wait_empty(30);

      // Reset in the middle of a multiply.
      issue(200, 3, 2);
      repeat (3) @(posedge clk);
      #2 nrst = 1'b0;
      #1;
      check("midreset_result", int'(result), 0);
      check("midreset_busy", int'(busy), 0);
      check("midreset_done", int'(done), 0);
      sb.delete();
      #4 nrst = 1'b1;
      @(posedge clk); #1;
      issue(1, 1, 0);
      wait_empty(30);

      for (int i = 0; i < 60; i++) begin
         int a, b, o;
         a = $urandom_range(0, 255);
         o = $urandom_range(0, 3);
         if (o == 1 && $urandom_range(0, 1) == 1) b = (a + $urandom_range(0, 20)) % 256;
         else if (o == 2) b = $urandom_range(0, 20);
         else if (o == 3 && $urandom_range(0, 7) == 0) b = 0;
         else b = $urandom_range(0, 255);
         issue(a, b, o);
         if ($urandom_range(0, 1) == 1) wait_done_rise(30);
         else wait_empty(30);
      end
      wait_empty(30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
